// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over a
// req/ack handshake, and selects the next PC from the controller's PCSrc/Jump on retire.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        PCSrc,
    input  logic        Jump,
    output logic [31:0] InstrCount
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        capture;
    logic        retire;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign capture    = (state_q == FETCH) && ImemAck;
    assign retire     = (state_q == HOLD) && InstrReady;

    // Jump outranks a taken branch; PCSrc/Jump only matter on the retiring edge.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (PCSrc) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (capture) begin
                    instr_d = ImemRData;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // All outputs derive from registers only.
    assign ImemReq    = (state_q == FETCH);
    assign InstrValid = (state_q == HOLD);
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign Instr      = instr_q;
    assign Op         = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: three instances with different reset PCs share one
// stimulus; expected fetch addresses are queued at retire and checked at the next request.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        pcsrc;
    logic        jump;

    logic        req   [3];
    logic [31:0] addr  [3];
    logic [31:0] instr [3];
    logic [5:0]  op    [3];
    logic [5:0]  funct [3];
    logic [31:0] pc    [3];
    logic [31:0] pcp4  [3];
    logic        valid [3];
    logic [31:0] cnt   [3];

    int          tests;
    int          fails;
    int          cycle;
    logic [31:0] exp_q[$];

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
        .Clk(clk), .Rst_n(rst_n), .ImemReq(req[0]), .ImemAddr(addr[0]), .ImemAck(imem_ack),
        .ImemRData(imem_rdata), .Instr(instr[0]), .Op(op[0]), .Funct(funct[0]), .PC(pc[0]),
        .PCPlus4(pcp4[0]), .InstrValid(valid[0]), .InstrReady(instr_ready), .PCSrc(pcsrc),
        .Jump(jump), .InstrCount(cnt[0])
    );

    mips_fetch_unit #(.RESET_PC(32'h4000_0010)) u1 (
        .Clk(clk), .Rst_n(rst_n), .ImemReq(req[1]), .ImemAddr(addr[1]), .ImemAck(imem_ack),
        .ImemRData(imem_rdata), .Instr(instr[1]), .Op(op[1]), .Funct(funct[1]), .PC(pc[1]),
        .PCPlus4(pcp4[1]), .InstrValid(valid[1]), .InstrReady(instr_ready), .PCSrc(pcsrc),
        .Jump(jump), .InstrCount(cnt[1])
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u2 (
        .Clk(clk), .Rst_n(rst_n), .ImemReq(req[2]), .ImemAddr(addr[2]), .ImemAck(imem_ack),
        .ImemRData(imem_rdata), .Instr(instr[2]), .Op(op[2]), .Funct(funct[2]), .PC(pc[2]),
        .PCPlus4(pcp4[2]), .InstrValid(valid[2]), .InstrReady(instr_ready), .PCSrc(pcsrc),
        .Jump(jump), .InstrCount(cnt[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic br, input logic jmp);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = cur + 32'd4;
        off = {{16{w[15]}}, w[15:0]};
        if (jmp) return {p4[31:28], w[25:0], 2'b00};
        if (br) return p4 + (off << 2);
        return p4;
    endfunction

    // Drives one complete fetch/retire transaction on u0, checking as it goes.
    task automatic do_instr(input logic [31:0] word, input int ack_wait, input int ready_wait,
                            input logic br, input logic jmp, output int req_cycle);
        logic [31:0] exp_pc;
        logic [31:0] cnt_before;
        int          n;
        n = 0;
        req_cycle = -1;
        while (req[0] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (req[0] !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL fetch_wait: ImemReq=%b queued=%0d, required 1 and a queued address",
                     req[0], exp_q.size());
            fails++;
            return;
        end
        req_cycle = cycle;
        exp_pc = exp_q.pop_front();
        tests++;
        if (addr[0] !== exp_pc) begin
            $display("FAIL imem_addr: got %h required %h", addr[0], exp_pc);
            fails++;
        end
        cnt_before = cnt[0];
        for (int i = 0; i < ack_wait; i++) begin
            instr_ready = 1'b1;
            pcsrc = 1'b1;
            jump = 1'b1;
            @(negedge clk);
            tests++;
            if (req[0] !== 1'b1 || addr[0] !== exp_pc || pc[0] !== exp_pc || cnt[0] !== cnt_before)
            begin
                $display("FAIL fetch_stall: req=%b addr=%h pc=%h cnt=%0d required 1 %h %h %0d",
                         req[0], addr[0], pc[0], cnt[0], exp_pc, exp_pc, cnt_before);
                fails++;
            end
        end
        instr_ready = 1'b0;
        pcsrc = 1'bx;
        jump = 1'bx;
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        tests++;
        if (valid[0] !== 1'b1 || req[0] !== 1'b0 || instr[0] !== word || op[0] !== word[31:26] ||
            funct[0] !== word[5:0] || pc[0] !== exp_pc || pcp4[0] !== exp_pc + 32'd4) begin
            $display("FAIL capture: valid=%b req=%b instr=%h op=%h funct=%h pc=%h pc4=%h required 1 0 %h %h %h %h %h",
                     valid[0], req[0], instr[0], op[0], funct[0], pc[0], pcp4[0], word,
                     word[31:26], word[5:0], exp_pc, exp_pc + 32'd4);
            fails++;
        end
        for (int i = 0; i < ready_wait; i++) begin
            imem_ack = 1'b1;
            imem_rdata = ~word;
            @(negedge clk);
            imem_ack = 1'b0;
            tests++;
            if (valid[0] !== 1'b1 || instr[0] !== word || pc[0] !== exp_pc ||
                cnt[0] !== cnt_before) begin
                $display("FAIL hold_stall: valid=%b instr=%h pc=%h cnt=%0d required 1 %h %h %0d",
                         valid[0], instr[0], pc[0], cnt[0], word, exp_pc, cnt_before);
                fails++;
            end
        end
        instr_ready = 1'b1;
        pcsrc = br;
        jump = jmp;
        exp_q.push_back(model_next(exp_pc, word, br, jmp));
        @(negedge clk);
        instr_ready = 1'b0;
        pcsrc = 1'bx;
        jump = 1'bx;
        tests++;
        if (valid[0] !== 1'b0 || cnt[0] !== cnt_before + 32'd1) begin
            $display("FAIL retire: valid=%b cnt=%0d required 0 %0d", valid[0], cnt[0],
                     cnt_before + 32'd1);
            fails++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (req[0] !== 1'b0 || valid[0] !== 1'b0 || addr[0] !== 32'h0 || pc[0] !== 32'h0 ||
            instr[0] !== 32'h0 || op[0] !== 6'h0 || funct[0] !== 6'h0 || pcp4[0] !== 32'h4 ||
            cnt[0] !== 32'h0) begin
            $display("FAIL reset_u0: req=%b valid=%b addr=%h instr=%h pc4=%h cnt=%0d required 0 0 0 0 4 0",
                     req[0], valid[0], addr[0], instr[0], pcp4[0], cnt[0]);
            fails++;
        end
        tests++;
        if (addr[1] !== 32'h4000_0010 || pcp4[2] !== 32'h0) begin
            $display("FAIL reset_pc_param: u1 addr=%h u2 pc4=%h required 40000010 00000000",
                     addr[1], pcp4[2]);
            fails++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (req[0] !== 1'b0) begin
            $display("FAIL idle_after_reset: ImemReq=%b required 0", req[0]);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (req[0] !== 1'b1 || valid[0] !== 1'b0) begin
            $display("FAIL first_fetch: req=%b valid=%b required 1 0", req[0], valid[0]);
            fails++;
        end
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    task automatic test_sequential;
        logic [31:0] words [4];
        int          rc [4];
        words[0] = 32'h0022_1820;
        words[1] = 32'h8C43_0004;
        words[2] = 32'h0000_0000;
        words[3] = 32'h2063_FFFF;
        for (int k = 0; k < 4; k++) begin
            do_instr(words[k], 0, 0, 1'b0, 1'b0, rc[k]);
            if (k == 0) begin
                tests++;
                if (addr[2] !== 32'h0 || addr[1] !== 32'h4000_0014) begin
                    $display("FAIL wrap: u2 addr=%h u1 addr=%h required 00000000 40000014",
                             addr[2], addr[1]);
                    fails++;
                end
            end
        end
        for (int k = 1; k < 4; k++) begin
            tests++;
            if (rc[k] - rc[k-1] != 2) begin
                $display("FAIL throughput: %0d cycles between requests, required 2",
                         rc[k] - rc[k-1]);
                fails++;
            end
        end
        tests++;
        if (cnt[0] !== 32'd4) begin
            $display("FAIL count_seq: InstrCount=%0d required 4", cnt[0]);
            fails++;
        end
    endtask

    task automatic test_stalls;
        int rc;
        do_instr(32'h012A_4020, 3, 2, 1'b0, 1'b0, rc);
        tests++;
        if (cnt[0] !== 32'd5) begin
            $display("FAIL count_stall: InstrCount=%0d required 5", cnt[0]);
            fails++;
        end
    endtask

    task automatic test_reset_mid_fetch;
        int n;
        n = 0;
        while (req[0] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (req[0] !== 1'b0 || pc[0] !== 32'h0 || cnt[0] !== 32'h0 || instr[0] !== 32'h0) begin
            $display("FAIL reset_mid: req=%b pc=%h cnt=%0d instr=%h required 0 0 0 0",
                     req[0], pc[0], cnt[0], instr[0]);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (req[0] !== 1'b0) begin
            $display("FAIL reset_mid_idle: ImemReq=%b required 0", req[0]);
            fails++;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        tests++;
        if (req[0] !== 1'b1 || valid[0] !== 1'b0 || instr[0] !== 32'h0 ||
            pc[1] !== 32'h4000_0010) begin
            $display("FAIL idle_ack_ignored: req=%b valid=%b instr=%h u1 pc=%h required 1 0 0 40000010",
                     req[0], valid[0], instr[0], pc[1]);
            fails++;
        end
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    task automatic test_jump_priority;
        int rc;
        do_instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, rc);
        tests++;
        if (addr[1] !== 32'h4000_0100 || addr[0] !== 32'h0000_0100) begin
            $display("FAIL jump_priority: u1 addr=%h u0 addr=%h required 40000100 00000100",
                     addr[1], addr[0]);
            fails++;
        end
    endtask

    task automatic test_branch;
        int rc;
        do_instr(32'h1000_FFFE, 0, 1, 1'b1, 1'b0, rc);
        tests++;
        if (addr[0] !== 32'h0000_00FC) begin
            $display("FAIL branch_taken: addr=%h required 000000fc", addr[0]);
            fails++;
        end
        do_instr(32'h0800_0040, 1, 0, 1'b0, 1'b1, rc);
        do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b0, rc);
        tests++;
        if (addr[0] !== 32'h0000_0104) begin
            $display("FAIL branch_not_taken: addr=%h required 00000104", addr[0]);
            fails++;
        end
    endtask

    task automatic test_drain;
        logic [31:0] exp_pc;
        tests++;
        if (exp_q.size() != 1 || req[0] !== 1'b1) begin
            $display("FAIL drain: queued=%0d req=%b required 1 1", exp_q.size(), req[0]);
            fails++;
        end else begin
            exp_pc = exp_q.pop_front();
            tests++;
            if (addr[0] !== exp_pc) begin
                $display("FAIL final_addr: got %h required %h", addr[0], exp_pc);
                fails++;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cycle = 0;
        test_reset();
        test_sequential();
        test_stalls();
        test_reset_mid_fetch();
        test_jump_priority();
        test_branch();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
